// File: rtl/keypad_entry.sv
// keypad_entry
// -----------------------------------------------------------------------------
// 4x4 matrix keypad front end for the CPU input bus. It scans the columns,
// debounces whole scan frames, and decodes one hex digit per press. Nine
// digits form one entry: SRCH, SRCL, DSTH, DSTL (two digits each), then
// ALU_OP (low 3 bits of the last digit). A complete entry is committed to the
// outputs on a single edge, and finish is raised at that point.
//
// Parameters
//   SCAN_DIV : clock cycles each column is driven (>= 2)
//   DEBOUNCE : consecutive identical frames needed to accept a press/release (>= 1)
//
// Ports
//   Clock     in   1  system clock
//   Reset     in   1  synchronous reset, active-high
//   H         in   4  row inputs, active-low (pulled up)
//   V         out  4  column drives, active-low, one-hot-low
//   SRCH      out  8  committed source operand, high byte
//   SRCL      out  8  committed source operand, low byte
//   DSTH      out  8  committed destination operand, high byte
//   DSTL      out  8  committed destination operand, low byte
//   ALU_OP    out  3  committed opcode
//   finish    out  1  high while a committed entry is unread
//
// Optional build macro ENTRY_ECHO_EN adds:
//   echo      out 16  staging word of the field currently being typed
//   digit_cnt out  4  digits entered so far in the current entry (0..8)
// -----------------------------------------------------------------------------
module keypad_entry #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] H,
  output logic [3:0] V,
  output logic [7:0] SRCH,
  output logic [7:0] SRCL,
  output logic [7:0] DSTH,
  output logic [7:0] DSTL,
  output logic [2:0] ALU_OP,
  output logic       finish
`ifdef ENTRY_ECHO_EN
  ,
  output logic [15:0] echo,
  output logic [3:0]  digit_cnt
`endif
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // ---------------------------------------------------------------------------
  // Column scan
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   dwell_reg;
  logic [1:0]      col_reg;
  logic [2:0][3:0] col_low_reg;   // active-high row hits of columns 0..2
  logic            sample;
  logic            frame_done_reg;
  logic            frame_hit_reg;
  logic [3:0]      frame_key_reg;
  logic            frame_hit;
  logic [3:0]      frame_key;

  assign sample = (dwell_reg == DWELL_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col_drive
      assign V[gi] = (col_reg != 2'(gi));
    end
    for (gi = 0; gi < 3; gi++) begin : g_col_capture
      always_ff @(posedge Clock) begin
        if (Reset) begin
          col_low_reg[gi] <= 4'b0000;
        end else if (sample && col_reg == 2'(gi)) begin
          col_low_reg[gi] <= ~H;
        end
      end
    end
  endgenerate

  // Column 3 is never stored: its sample is the frame's last, so it is taken
  // straight from H and combined with the stored columns on the same edge.
  always_comb begin
    logic [15:0] frame_vec;
    logic        seen;
    logic        multi;
    logic [3:0]  idx;
    frame_vec = {~H, col_low_reg[2], col_low_reg[1], col_low_reg[0]};
    seen      = 1'b0;
    multi     = 1'b0;
    frame_key = 4'h0;
    idx       = 4'h0;
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      if (frame_vec[i]) begin
        if (seen) begin
          multi = 1'b1;
        end
        seen      = 1'b1;
        // frame_vec is column-major ({col,row}); the key code is {row,col}
        frame_key = {idx[1:0], idx[3:2]};
      end
    end
    // two or more low rows in one frame are ghosting and count as no key
    frame_hit = seen & ~multi;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      dwell_reg      <= '0;
      col_reg        <= 2'd0;
      frame_done_reg <= 1'b0;
      frame_hit_reg  <= 1'b0;
      frame_key_reg  <= 4'h0;
    end else begin
      frame_done_reg <= 1'b0;
      if (sample) begin
        dwell_reg <= '0;
        col_reg   <= col_reg + 2'd1;
        if (col_reg == 2'd3) begin
          frame_done_reg <= 1'b1;
          frame_hit_reg  <= frame_hit;
          frame_key_reg  <= frame_key;
        end
      end else begin
        dwell_reg <= dwell_reg + DW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM, evaluated once per completed frame
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    REL_CHK
  } db_state_t;

  db_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [3:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_inc;
  logic          key_evt;

  assign cnt_inc = cnt_reg + CNT_ONE;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      cand_reg  <= 4'h0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cand_reg  <= cand_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cand_next  = cand_reg;
    key_evt    = 1'b0;
    if (frame_done_reg) begin
      case (state_reg)
        RELEASED: begin
          if (frame_hit_reg) begin
            cand_next = frame_key_reg;
            cnt_next  = CNT_ONE;
            // with DEBOUNCE=1 the first frame already satisfies the count
            if (DB_MAX == CNT_ONE) begin
              key_evt    = 1'b1;
              state_next = HELD;
            end else begin
              state_next = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (!frame_hit_reg) begin
            state_next = RELEASED;
          end else if (frame_key_reg != cand_reg) begin
            cand_next = frame_key_reg;
            cnt_next  = CNT_ONE;
          end else begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              key_evt    = 1'b1;
              state_next = HELD;
            end
          end
        end
        HELD: begin
          if (!frame_hit_reg) begin
            cnt_next   = CNT_ONE;
            state_next = (DB_MAX == CNT_ONE) ? RELEASED : REL_CHK;
          end
        end
        REL_CHK: begin
          if (frame_hit_reg) begin
            state_next = HELD;
          end else begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_next = RELEASED;
            end
          end
        end
        default: state_next = RELEASED;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry assembly: digits go to staging; the ninth digit commits everything
  // ---------------------------------------------------------------------------
  logic [3:0]  digit_cnt_reg;
  logic [15:0] src_stage_reg;
  logic [15:0] dst_stage_reg;
  logic [7:0]  srch_reg, srcl_reg, dsth_reg, dstl_reg;
  logic [2:0]  alu_op_reg;
  logic        finish_reg;

  // the accepted key is the frame that completed the debounce
  always_ff @(posedge Clock) begin
    if (Reset) begin
      digit_cnt_reg <= 4'd0;
      src_stage_reg <= 16'h0000;
      dst_stage_reg <= 16'h0000;
      srch_reg      <= 8'h00;
      srcl_reg      <= 8'h00;
      dsth_reg      <= 8'h00;
      dstl_reg      <= 8'h00;
      alu_op_reg    <= 3'd0;
      finish_reg    <= 1'b0;
    end else if (key_evt) begin
      // any new digit acknowledges a pending entry
      finish_reg    <= 1'b0;
      digit_cnt_reg <= digit_cnt_reg + 4'd1;
      case (digit_cnt_reg)
        4'd0: src_stage_reg[15:12] <= frame_key_reg;
        4'd1: src_stage_reg[11:8]  <= frame_key_reg;
        4'd2: src_stage_reg[7:4]   <= frame_key_reg;
        4'd3: src_stage_reg[3:0]   <= frame_key_reg;
        4'd4: dst_stage_reg[15:12] <= frame_key_reg;
        4'd5: dst_stage_reg[11:8]  <= frame_key_reg;
        4'd6: dst_stage_reg[7:4]   <= frame_key_reg;
        4'd7: dst_stage_reg[3:0]   <= frame_key_reg;
        default: begin
          srch_reg      <= src_stage_reg[15:8];
          srcl_reg      <= src_stage_reg[7:0];
          dsth_reg      <= dst_stage_reg[15:8];
          dstl_reg      <= dst_stage_reg[7:0];
          alu_op_reg    <= frame_key_reg[2:0];
          finish_reg    <= 1'b1;
          digit_cnt_reg <= 4'd0;
        end
      endcase
    end
  end

  assign SRCH   = srch_reg;
  assign SRCL   = srcl_reg;
  assign DSTH   = dsth_reg;
  assign DSTL   = dstl_reg;
  assign ALU_OP = alu_op_reg;
  assign finish = finish_reg;

`ifdef ENTRY_ECHO_EN
  // the committed opcode doubles as the "last staged opcode" preview
  always_comb begin
    if (digit_cnt_reg < 4'd4) begin
      echo = src_stage_reg;
    end else if (digit_cnt_reg < 4'd8) begin
      echo = dst_stage_reg;
    end else begin
      echo = {13'b0, alu_op_reg};
    end
  end
  assign digit_cnt = digit_cnt_reg;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry
// Drives a modelled 4x4 key matrix (rows pulled low by pressed keys on the
// driven column), checks scan rotation and reset state, and scores committed
// entries against a queue of expected values filled as digits are typed.
module tb_keypad_entry;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FRAME = 4 * SD;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] H;
  logic [3:0] V;
  logic [7:0] SRCH, SRCL, DSTH, DSTL;
  logic [2:0] ALU_OP;
  logic       finish;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .H     (H),
    .V     (V),
    .SRCH  (SRCH),
    .SRCL  (SRCL),
    .DSTH  (DSTH),
    .DSTL  (DSTL),
    .ALU_OP(ALU_OP),
    .finish(finish)
  );

  always #5 Clock = ~Clock;

  // key matrix: pressed[k] with k = {row,col}
  logic [15:0] pressed = 16'h0000;
  always_comb begin
    H = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[r*4+c] && !V[c]) H[r] = 1'b0;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  typedef struct packed {
    logic [7:0] srch;
    logic [7:0] srcl;
    logic [7:0] dsth;
    logic [7:0] dstl;
    logic [2:0] op;
  } commit_t;

  commit_t    sb_q[$];
  commit_t    cur_exp = '0;
  logic       fin_exp = 1'b0;
  int         d_model = 0;
  logic [3:0] stage_m[8];
  commit_t    out_now;

  assign out_now = {SRCH, SRCL, DSTH, DSTL, ALU_OP};

  // commit monitor: any output change or finish rising must match the queue
  commit_t prev_out = '0;
  logic    prev_fin = 1'b0;
  always @(negedge Clock) begin
    commit_t e;
    if (!Reset && ((finish && !prev_fin) || out_now != prev_out)) begin
      check_val("sb_pending", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_val("commit", 64'(out_now), 64'(e));
        check_val("commit_finish", 64'(finish), 64'd1);
      end
    end
    prev_out <= out_now;
    prev_fin <= finish;
  end

  // align to the first cycle of column 0, i.e. the start of a frame
  task automatic sync_frame();
    int t = 0;
    while (V !== 4'b0111 && t < 64) begin @(negedge Clock); t++; end
    while (V !== 4'b1110 && t < 64) begin @(negedge Clock); t++; end
    if (t >= 64) check_val("sync_timeout", 64'(t), 64'd0);
  endtask

  task automatic hold(input logic [15:0] mask, input int frames);
    sync_frame();
    pressed = mask;
    repeat (FRAME * frames) @(negedge Clock);
    pressed = 16'h0000;
  endtask

  task automatic idle_frames(input int frames);
    repeat (FRAME * frames) @(negedge Clock);
  endtask

  task automatic check_steady(input string tag);
    check_val({tag, "_out"}, 64'(out_now), 64'(cur_exp));
    check_val({tag, "_fin"}, 64'(finish), 64'(fin_exp));
  endtask

  task automatic press_digit(input logic [3:0] k, input int frames);
    commit_t e;
    if (d_model == 8) begin
      e = {stage_m[0], stage_m[1], stage_m[2], stage_m[3],
           stage_m[4], stage_m[5], stage_m[6], stage_m[7], k[2:0]};
      sb_q.push_back(e);
      cur_exp = e;
      d_model = 0;
      fin_exp = 1'b1;
    end else begin
      stage_m[d_model] = k;
      d_model++;
      fin_exp = 1'b0;
    end
    hold(16'(1) << k, frames);
    idle_frames(DB);
    check_steady($sformatf("key%0h_d%0d", k, d_model));
  endtask

  logic [3:0] rot_exp[4];

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rot_exp[0] = 4'b1101;
    rot_exp[1] = 4'b1011;
    rot_exp[2] = 4'b0111;
    rot_exp[3] = 4'b1110;

    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    check_val("reset_V", 64'(V), 64'(4'b1110));
    check_steady("reset");
    for (int i = 0; i < 4; i++) begin
      repeat (SD) @(negedge Clock);
      check_val($sformatf("rot%0d", i), 64'(V), 64'(rot_exp[i]));
    end

    // entry 1: long hold, bounce and ghost frames must not add digits
    press_digit(4'h1, 10);
    press_digit(4'h2, 2);
    hold(16'h0008, 1); idle_frames(1);            // bounce on key 3
    pressed = 16'h0008; idle_frames(1); pressed = 16'h0000;
    idle_frames(2);
    check_steady("bounce");
    press_digit(4'h3, 2);
    press_digit(4'h4, 2);
    press_digit(4'hA, 2);
    hold(16'h0202, 2); idle_frames(2);            // rows 0,2 on column 1
    check_steady("ghost_same_col");
    hold(16'h0801, 2); idle_frames(2);            // rows 0,2 on columns 0,3
    check_steady("ghost_diff_col");
    press_digit(4'hB, 2);
    press_digit(4'hC, 2);
    press_digit(4'hD, 2);
    press_digit(4'h5, 2);

    // entry 2: first digit acknowledges entry 1, outputs held meanwhile
    press_digit(4'h7, 2);
    press_digit(4'h6, 2);
    press_digit(4'h5, 2);
    press_digit(4'h4, 2);
    press_digit(4'h3, 2);
    press_digit(4'h2, 2);
    press_digit(4'h1, 2);
    press_digit(4'h0, 2);
    press_digit(4'hF, 2);

    // entry 3: abandoned by reset after five digits
    for (int i = 0; i < 5; i++) press_digit(4'h9, 2);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    cur_exp = '0;
    fin_exp = 1'b0;
    d_model = 0;
    check_val("midreset_V", 64'(V), 64'(4'b1110));
    check_steady("midreset");
    Reset = 1'b0;

    // entry 4: full entry after reset, opcode digit has key[3] set
    press_digit(4'hF, 2);
    press_digit(4'hE, 2);
    press_digit(4'h0, 2);
    press_digit(4'h9, 2);
    press_digit(4'h8, 2);
    press_digit(4'h7, 2);
    press_digit(4'h3, 2);
    press_digit(4'h2, 2);
    press_digit(4'hE, 2);

    repeat (10) @(negedge Clock);
    check_val("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
